// File: rtl/add_sub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor slice.
// Holds the operation encoding, result flag bundle and saturation limits.
package add_sub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

  localparam int unsigned SAT_MAX_W = 256;

  // Returns the most-negative (negative=1) or most-positive limit for a
  // bit_w-wide two's-complement value in the low bit_w bits.
  function automatic logic [SAT_MAX_W-1:0] sat_limit(input int unsigned bit_w,
                                                     input logic negative);
    logic [SAT_MAX_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < SAT_MAX_W; i++) begin
      if (i + 1 < bit_w) v[i] = ~negative;
      else if (i + 1 == bit_w) v[i] = negative;
    end
    return v;
  endfunction

endpackage

// File: rtl/add_sub_chunk.sv
// W-bit ripple-carry adder chunk with carry in/out, built from full_adder cells.
module add_sub_chunk #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // Per-bit carry nets keep the ripple free of self-referencing vectors.
  for (genvar i = 0; i < W; i++) begin : g_bit
    logic ci;
    logic co;
    if (i == 0) begin : g_c0
      assign ci = cin;
    end else begin : g_cn
      assign ci = g_bit[i-1].co;
    end
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (ci),
      .sum (sum[i]),
      .cout(co)
    );
  end

  assign cout = g_bit[W-1].co;

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the ripple chunks.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined add/sub: one W-bit chunk per stage, carry registered between stages.
// Optional saturation in the final stage when ADD_SUB_SAT_EN is defined.
module pipelined_add_sub
  import add_sub_pkg::*;
#(
  parameter int unsigned BIT    = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           valid_i,
  output logic           ready_o,
  input  logic [BIT-1:0] a_i,
  input  logic [BIT-1:0] b_i,
  input  logic           sub_i,
`ifdef ADD_SUB_SAT_EN
  input  logic           sat_i,
`endif
  output logic           valid_o,
  input  logic           ready_i,
  output logic [BIT-1:0] result_o,
  output logic           carry_o,
  output logic           ovf_o,
  output logic           zero_o,
  output logic           neg_o
);

  localparam int unsigned W = BIT / STAGES;

  logic           en;
  logic           v_q  [STAGES];
  logic           v_d  [STAGES];
  logic [BIT-1:0] a_q  [STAGES];
  logic [BIT-1:0] a_d  [STAGES];
  logic [BIT-1:0] b_q  [STAGES];
  logic [BIT-1:0] b_d  [STAGES];
  logic           c_q  [STAGES];
  logic           c_d  [STAGES];
  op_e            op_q [STAGES];
  op_e            op_d [STAGES];
`ifdef ADD_SUB_SAT_EN
  logic           sat_q[STAGES];
  logic           sat_d[STAGES];
`endif
  flags_t         flags_q;
  flags_t         flags_d;

  assign en      = !v_q[STAGES-1] || ready_i;
  assign ready_o = en;

  // The A word doubles as the result: finished chunks overwrite A in place.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [BIT-1:0] a_s;
    logic [BIT-1:0] b_s;
    logic [BIT-1:0] a_mix;
    logic           c_s;
    logic           v_s;
    op_e            op_s;
    logic [W-1:0]   sum;
    logic           cout;
`ifdef ADD_SUB_SAT_EN
    logic           sat_s;
`endif

    if (k == 0) begin : g_in
      assign a_s  = a_i;
      assign b_s  = b_i ^ {BIT{sub_i}};
      assign c_s  = sub_i;
      assign v_s  = valid_i;
      assign op_s = sub_i ? OP_SUB : OP_ADD;
`ifdef ADD_SUB_SAT_EN
      assign sat_s = sat_i;
`endif
    end else begin : g_mid
      assign a_s  = a_q[k-1];
      assign b_s  = b_q[k-1];
      assign c_s  = c_q[k-1];
      assign v_s  = v_q[k-1];
      assign op_s = op_q[k-1];
`ifdef ADD_SUB_SAT_EN
      assign sat_s = sat_q[k-1];
`endif
    end

    add_sub_chunk #(.W(W)) u_chunk (
      .a   (a_s[k*W +: W]),
      .b   (b_s[k*W +: W]),
      .cin (c_s),
      .sum (sum),
      .cout(cout)
    );

    always_comb begin
      a_mix = a_s;
      a_mix[k*W +: W] = sum;
    end

    assign v_d[k]  = v_s;
    assign b_d[k]  = b_s;
    assign c_d[k]  = cout;
    assign op_d[k] = op_s;
`ifdef ADD_SUB_SAT_EN
    assign sat_d[k] = sat_s;
`endif

    if (k == STAGES - 1) begin : g_last
      logic           ovf;
      logic [BIT-1:0] res;
      // a_s[BIT-1] is still the original A sign: the top chunk is replaced only in a_mix.
      assign ovf = (a_s[BIT-1] == b_s[BIT-1]) && (a_mix[BIT-1] != a_s[BIT-1]);
`ifdef ADD_SUB_SAT_EN
      logic [SAT_MAX_W-1:0] lim;
      assign lim = sat_limit(BIT, a_s[BIT-1]);
      assign res = (sat_s && ovf) ? lim[BIT-1:0] : a_mix;
`else
      assign res = a_mix;
`endif
      assign a_d[k]        = res;
      assign flags_d.carry = (op_s == OP_SUB) ? ~cout : cout;
      assign flags_d.ovf   = ovf;
      assign flags_d.zero  = (res == '0);
      assign flags_d.neg   = res[BIT-1];
    end else begin : g_pass
      assign a_d[k] = a_mix;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k]  <= 1'b0;
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        c_q[k]  <= 1'b0;
        op_q[k] <= OP_ADD;
`ifdef ADD_SUB_SAT_EN
        sat_q[k] <= 1'b0;
`endif
      end
      flags_q <= '0;
    end else if (en) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k]  <= v_d[k];
        a_q[k]  <= a_d[k];
        b_q[k]  <= b_d[k];
        c_q[k]  <= c_d[k];
        op_q[k] <= op_d[k];
`ifdef ADD_SUB_SAT_EN
        sat_q[k] <= sat_d[k];
`endif
      end
      flags_q <= flags_d;
    end
  end

  assign valid_o  = v_q[STAGES-1];
  assign result_o = a_q[STAGES-1];
  assign carry_o  = flags_q.carry;
  assign ovf_o    = flags_q.ovf;
  assign zero_o   = flags_q.zero;
  assign neg_o    = flags_q.neg;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub at STAGES = 4, 1 and 32 with a queue scoreboard.
module tb_pipelined_add_sub;

  localparam int unsigned BIT = 32;
  localparam int unsigned ND  = 3;
  localparam int unsigned ST [ND] = '{4, 1, 32};
`ifdef ADD_SUB_SAT_EN
  localparam bit SAT_BUILT = 1'b1;
`else
  localparam bit SAT_BUILT = 1'b0;
`endif

  localparam int unsigned NV = 7;
  localparam logic [31:0] VA [NV] = '{32'hFFFFFFFF, 32'd5, 32'd7, 32'h80000000,
                                      32'h80000000, 32'h7FFFFFFF, 32'd0};
  localparam logic [31:0] VB [NV] = '{32'h00000001, 32'd7, 32'd5, 32'h00000001,
                                      32'h00000001, 32'h00000001, 32'd0};
  localparam bit VS   [NV] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam bit VSAT [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam bit PAT  [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst_n;
  logic           in_valid [ND];
  logic           in_ready [ND];
  logic           in_sub   [ND];
  logic           in_sat   [ND];
  logic [BIT-1:0] in_a     [ND];
  logic [BIT-1:0] in_b     [ND];
  logic           out_ready[ND];
  logic           out_valid[ND];
  logic           out_carry[ND];
  logic           out_ovf  [ND];
  logic           out_zero [ND];
  logic           out_neg  [ND];
  logic [BIT-1:0] out_res  [ND];

  int checks = 0;
  int errors = 0;
  logic [35:0] sb[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    pipelined_add_sub #(.BIT(BIT), .STAGES(ST[g])) u_dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .valid_i (in_valid[g]),
      .ready_o (out_ready[g]),
      .a_i     (in_a[g]),
      .b_i     (in_b[g]),
      .sub_i   (in_sub[g]),
`ifdef ADD_SUB_SAT_EN
      .sat_i   (in_sat[g]),
`endif
      .valid_o (out_valid[g]),
      .ready_i (in_ready[g]),
      .result_o(out_res[g]),
      .carry_o (out_carry[g]),
      .ovf_o   (out_ovf[g]),
      .zero_o  (out_zero[g]),
      .neg_o   (out_neg[g])
    );
  end

  // Reference: {carry/borrow, ovf, zero, neg, result}
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sub, input logic sat);
    logic [32:0] s;
    longint      sa, sb_, r;
    logic        c, o;
    logic [31:0] res;
    sa = $signed(a);
    sb_ = $signed(b);
    if (sub) begin
      s = {1'b0, a} - {1'b0, b};
      c = (a < b);
      r = sa - sb_;
    end else begin
      s = {1'b0, a} + {1'b0, b};
      c = s[32];
      r = sa + sb_;
    end
    res = s[31:0];
    o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    if (SAT_BUILT && sat && o) res = a[31] ? 32'h80000000 : 32'h7FFFFFFF;
    return {c, o, (res == 32'd0), res[31], res};
  endfunction

  function automatic logic [35:0] observed(input int d);
    return {out_carry[d], out_ovf[d], out_zero[d], out_neg[d], out_res[d]};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < int'(ND); d++) begin
      checks++;
      if (out_valid[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_valid d=%0d got=%b exp=0", d, out_valid[d]);
      end
      checks++;
      if (observed(d) !== 36'd0) begin
        errors++;
        $display("FAIL reset_outputs d=%0d got=%h exp=%h", d, observed(d), 36'd0);
      end
      checks++;
      if (out_ready[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_ready d=%0d got=%b exp=1", d, out_ready[d]);
      end
    end
  endtask

  task automatic test_directed(input int d);
    int  s;
    bit  found;
    logic [35:0] exp;
    s = int'(ST[d]);
    sb.delete();
    for (int i = 0; i < int'(NV); i++) begin
      @(posedge clk);
      #1;
      in_ready[d] = 1'b1;
      in_valid[d] = 1'b1;
      in_a[d]     = VA[i];
      in_b[d]     = VB[i];
      in_sub[d]   = VS[i];
      in_sat[d]   = VSAT[i];
      @(negedge clk);
      checks++;
      if (out_ready[d] !== 1'b1) begin
        errors++;
        $display("FAIL directed_ready d=%0d vec=%0d got=%b exp=1", d, i, out_ready[d]);
      end else begin
        sb.push_back(model(in_a[d], in_b[d], in_sub[d], in_sat[d]));
      end
      @(posedge clk);
      #1 in_valid[d] = 1'b0;
      found = 1'b0;
      for (int n = 1; n <= s + 4 && !found; n++) begin
        @(negedge clk);
        if (out_valid[d] === 1'b1) begin
          found = 1'b1;
          checks++;
          if (n != s) begin
            errors++;
            $display("FAIL directed_latency d=%0d vec=%0d got=%0d exp=%0d", d, i, n, s);
          end
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL directed_unexpected d=%0d vec=%0d got=%h exp=none", d, i, observed(d));
          end else begin
            exp = sb.pop_front();
            if (observed(d) !== exp) begin
              errors++;
              $display("FAIL directed_result d=%0d vec=%0d got=%h exp=%h", d, i, observed(d), exp);
            end
          end
        end
      end
      if (!found) begin
        checks++;
        errors++;
        $display("FAIL directed_timeout d=%0d vec=%0d got=no_valid exp=valid_after_%0d", d, i, s);
      end
    end
  endtask

  task automatic test_back_to_back(input int d);
    logic [31:0] ta [16];
    logic [31:0] tb [16];
    logic        ts [16];
    logic        tt [16];
    int          idx, got, cyc;
    logic        held;
    logic [35:0] snap, exp;
    for (int i = 0; i < 16; i++) begin
      ta[i] = $urandom;
      tb[i] = $urandom;
      ts[i] = 1'($urandom_range(0, 1));
      tt[i] = 1'($urandom_range(0, 1));
    end
    sb.delete();
    idx = 0; got = 0; cyc = 0; held = 1'b0; snap = '0;
    while (got < 16 && cyc < 600) begin
      @(posedge clk);
      #1;
      in_ready[d] = PAT[cyc % 4];
      in_valid[d] = (idx < 16);
      if (idx < 16) begin
        in_a[d] = ta[idx]; in_b[d] = tb[idx]; in_sub[d] = ts[idx]; in_sat[d] = tt[idx];
      end
      @(negedge clk);
      checks++;
      if (out_ready[d] !== !(out_valid[d] && !in_ready[d])) begin
        errors++;
        $display("FAIL b2b_ready d=%0d cyc=%0d got=%b exp=%b", d, cyc, out_ready[d],
                 !(out_valid[d] && !in_ready[d]));
      end
      if (held) begin
        checks++;
        if ({out_valid[d], observed(d)} !== {1'b1, snap}) begin
          errors++;
          $display("FAIL b2b_stall_hold d=%0d cyc=%0d got=%b_%h exp=1_%h", d, cyc,
                   out_valid[d], observed(d), snap);
        end
      end
      if (out_valid[d] && in_ready[d]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected d=%0d got=%h exp=none", d, observed(d));
        end else begin
          exp = sb.pop_front();
          if (observed(d) !== exp) begin
            errors++;
            $display("FAIL b2b_result d=%0d n=%0d got=%h exp=%h", d, got, observed(d), exp);
          end
        end
        got++;
      end
      held = out_valid[d] && !in_ready[d];
      snap = observed(d);
      if (in_valid[d] && out_ready[d]) begin
        sb.push_back(model(in_a[d], in_b[d], in_sub[d], in_sat[d]));
        idx++;
      end
      cyc++;
    end
    in_valid[d] = 1'b0;
    in_ready[d] = 1'b1;
    checks++;
    if (got != 16) begin
      errors++;
      $display("FAIL b2b_count d=%0d got=%0d exp=16", d, got);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_leftover d=%0d got=%0d exp=0", d, sb.size());
    end
  endtask

  task automatic test_reset_midstream(input int d);
    bit stale;
    in_ready[d] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      in_valid[d] = 1'b1;
      in_a[d]     = 32'(i * 3 + 1);
      in_b[d]     = 32'(i);
      in_sub[d]   = i[0];
      in_sat[d]   = 1'b0;
    end
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    rst_n       = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid[d] !== 1'b0) begin
      errors++;
      $display("FAIL midreset_valid d=%0d got=%b exp=0", d, out_valid[d]);
    end
    checks++;
    if (out_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready d=%0d got=%b exp=1", d, out_ready[d]);
    end
    stale = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid[d] !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      errors++;
      $display("FAIL midreset_stale d=%0d got=stale_valid exp=none", d);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < int'(ND); d++) begin
      in_valid[d] = 1'b0; in_ready[d] = 1'b1; in_sub[d] = 1'b0; in_sat[d] = 1'b0;
      in_a[d] = '0; in_b[d] = '0;
    end
    test_reset();
    for (int d = 0; d < int'(ND); d++) test_directed(d);
    for (int d = 0; d < int'(ND); d++) test_back_to_back(d);
    for (int d = 0; d < int'(ND); d++) test_reset_midstream(d);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
